// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares the single-port synchronous frame-buffer RAM between the processor
//   datapath (read/write) and the VGA pixel fetcher (read only). One access is
//   issued every two clocks (IDLE -> SERVE_x -> IDLE). VGA has fixed priority,
//   but after STARVE_MAX consecutive VGA grants with the CPU waiting, the CPU
//   is forced in.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   enabledVGA                  gates vga_req (0 = VGA requests ignored)
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ack
//   cpu_ack                     one-cycle pulse, CPU access issued
//   cpu_rdata, cpu_rvalid       CPU read data (held) and its update pulse
//   vga_req/addr                VGA read request, held until vga_ack
//   vga_ack                     one-cycle pulse, VGA access issued
//   vga_rdata, vga_rvalid       VGA read data (held) and its update pulse
//   mem_addr/we/wdata           registered RAM controls
//   mem_rdata                   RAM data, valid the cycle after address sample
module fb_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enabledVGA,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_VGA = 2'd1,
    SERVE_CPU = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       vga_win;
  logic       cpu_win;
  logic [3:0] starve_cnt;

  logic       cpu_vld_p0;
  logic       vga_vld_p0;
  logic       cpu_vld_p1;
  logic       vga_vld_p1;

  // Saturating increment of the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    vga_win = 1'b0;
    cpu_win = 1'b0;
    case (state_q)
      IDLE: begin
        if (vga_req && enabledVGA && !(cpu_req && (starve_cnt == STARVE_LIM))) begin
          vga_win = 1'b1;
          state_d = SERVE_VGA;
        end else if (cpu_req) begin
          cpu_win = 1'b1;
          state_d = SERVE_CPU;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Acks decode straight from the state register so an asynchronous reset
  // removes them without waiting for a clock edge.
  assign cpu_ack = (state_q == SERVE_CPU);
  assign vga_ack = (state_q == SERVE_VGA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        SERVE_VGA: if (cpu_req) starve_cnt <= sat_inc(starve_cnt);
        SERVE_CPU: starve_cnt <= 4'd0;
        default:   if (!cpu_req) starve_cnt <= 4'd0;
      endcase
    end
  end

  // Stage p0: winner's request registered onto the RAM port (SERVE cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= cpu_win & cpu_we;
      if (vga_win) begin
        mem_addr <= vga_addr;
      end else if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
    end
  end

  // Stage p1: RAM samples the address; read data is on mem_rdata next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_vld_p0 <= 1'b0;
      vga_vld_p0 <= 1'b0;
    end else begin
      cpu_vld_p0 <= cpu_ack & ~mem_we;
      vga_vld_p0 <= vga_ack;
    end
  end

  // Stage p2: capture read data into the owning requester's holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_vld_p1 <= 1'b0;
      vga_vld_p1 <= 1'b0;
      cpu_rdata  <= '0;
      vga_rdata  <= '0;
    end else begin
      cpu_vld_p1 <= cpu_vld_p0;
      vga_vld_p1 <= vga_vld_p0;
      if (cpu_vld_p0) cpu_rdata <= mem_rdata;
      if (vga_vld_p0) vga_rdata <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_vld_p1;
  assign vga_rvalid = vga_vld_p1;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter
//   Bench for fb_mem_arbiter with a behavioural synchronous RAM, a shadow copy
//   of the expected memory contents and per-requester read-data scoreboards.
module tb_fb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enabledVGA = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              vga_req = 1'b0;
  logic [ADDR_W-1:0] vga_addr = '0;
  logic              vga_ack;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  fb_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .enabledVGA(enabledVGA),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  logic [DATA_W-1:0] ram    [0:65535];
  logic [DATA_W-1:0] shadow [0:65535];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] cpu_exp_q[$];
  logic [DATA_W-1:0] vga_exp_q[$];
  byte               grant_log[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int i);
    logic [15:0] a;
    a = 16'(i);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
  endfunction

  // Output monitor: rvalid timing, read-data scoreboard, grant log.
  bit cpu_rd_d1 = 0, cpu_rd_d2 = 0, vga_rd_d1 = 0, vga_rd_d2 = 0;
  always @(negedge clk) begin
    if (reset) begin
      cpu_rd_d1 = 0; cpu_rd_d2 = 0; vga_rd_d1 = 0; vga_rd_d2 = 0;
    end else begin
      if (cpu_rvalid || cpu_rd_d2) chk("cpu_rvalid_timing", 64'(cpu_rvalid), 64'(cpu_rd_d2));
      if (vga_rvalid || vga_rd_d2) chk("vga_rvalid_timing", 64'(vga_rvalid), 64'(vga_rd_d2));
      if (cpu_rvalid) begin
        chk("cpu_rv_has_exp", 64'(cpu_exp_q.size() > 0), 64'(1));
        if (cpu_exp_q.size() > 0) chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_exp_q.pop_front()));
      end
      if (vga_rvalid) begin
        chk("vga_rv_has_exp", 64'(vga_exp_q.size() > 0), 64'(1));
        if (vga_exp_q.size() > 0) chk("vga_rdata", 64'(vga_rdata), 64'(vga_exp_q.pop_front()));
      end
      if (cpu_ack || vga_ack) chk("single_ack", 64'(cpu_ack && vga_ack), 64'(0));
      if (mem_we) chk("mem_we_in_cpu_ack", 64'(cpu_ack), 64'(1));
      if (vga_ack) grant_log.push_back(8'h56);
      if (cpu_ack) grant_log.push_back(8'h43);
      cpu_rd_d2 = cpu_rd_d1; cpu_rd_d1 = cpu_ack && !cpu_we;
      vga_rd_d2 = vga_rd_d1; vga_rd_d1 = vga_ack;
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr,
                            input logic [7:0] wdata, output int lat);
    int n;
    bit got;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) cpu_exp_q.push_back(shadow[addr]);
    else     shadow[addr] = wdata;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(negedge clk); n++;
      if (cpu_ack) got = 1;
    end
    chk("cpu_ack_seen", 64'(got), 64'(1));
    if (got) begin
      chk("cpu_mem_addr", 64'(mem_addr), 64'(addr));
      chk("cpu_mem_we", 64'(mem_we), 64'(we));
      if (we) chk("cpu_mem_wdata", 64'(mem_wdata), 64'(wdata));
    end
    lat = n - 1;
    @(posedge clk); #1;
  endtask

  task automatic vga_read(input logic [15:0] addr, output int lat);
    int n;
    bit got;
    vga_req = 1'b1; vga_addr = addr;
    vga_exp_q.push_back(shadow[addr]);
    n = 0; got = 0;
    while (n < 60 && !got) begin
      @(negedge clk); n++;
      if (vga_ack) got = 1;
    end
    chk("vga_ack_seen", 64'(got), 64'(1));
    if (got) begin
      chk("vga_mem_addr", 64'(mem_addr), 64'(addr));
      chk("vga_mem_we", 64'(mem_we), 64'(0));
    end
    lat = n - 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({cpu_ack, cpu_rdata, cpu_rvalid, vga_ack, vga_rdata, vga_rvalid,
                mem_addr, mem_we, mem_wdata});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, vlat, clat, max_lat, n;
    bit got, seen;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = init_val(i);
      shadow[i] = init_val(i);
    end

    // Reset, then idle with no requests.
    #25;
    chk("outputs_in_reset", out_vec(), 64'(0));
    #26 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", out_vec(), 64'(0));
    end
    @(posedge clk); #1;

    // CPU write then read back.
    cpu_access(1'b1, 16'h0123, 8'hA5, lat);
    chk("cpu_wr_lat", 64'(lat), 64'(1));
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (3) @(posedge clk); #1;
    cpu_access(1'b0, 16'h0123, 8'h00, lat);
    chk("cpu_rd_lat", 64'(lat), 64'(1));
    cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_rvalid_not_early", 64'(cpu_rvalid), 64'(0));
    @(negedge clk);
    chk("cpu_rvalid_2_after_ack", 64'(cpu_rvalid), 64'(1));
    chk("cpu_rdata_a5", 64'(cpu_rdata), 64'(8'hA5));
    repeat (2) @(posedge clk); #1;

    // Simultaneous single requests: VGA first, CPU two cycles later.
    fork
      begin vga_read(16'h0010, vlat); vga_req = 1'b0; end
      begin cpu_access(1'b0, 16'h0020, 8'h00, clat); cpu_req = 1'b0; end
    join
    chk("simul_vga_lat", 64'(vlat), 64'(1));
    chk("simul_cpu_lat", 64'(clat), 64'(3));
    repeat (4) @(posedge clk); #1;
    chk("simul_vga_rdata_hold", 64'(vga_rdata), 64'(shadow[16'h0010]));
    chk("simul_cpu_rdata_hold", 64'(cpu_rdata), 64'(shadow[16'h0020]));

    // enabledVGA gating.
    enabledVGA = 1'b0; vga_addr = 16'h0040; vga_req = 1'b1;
    vga_exp_q.push_back(shadow[16'h0040]);
    seen = 0;
    repeat (8) begin @(negedge clk); if (vga_ack) seen = 1; end
    chk("vga_ack_while_disabled", 64'(seen), 64'(0));
    @(posedge clk); #1 enabledVGA = 1'b1;
    n = 0; got = 0;
    while (n < 6 && !got) begin @(negedge clk); n++; if (vga_ack) got = 1; end
    chk("vga_ack_after_enable", 64'(got), 64'(1));
    chk("vga_enable_within_2", 64'((n - 1) <= 2), 64'(1));
    #2 enabledVGA = 1'b0;
    @(posedge clk); #1 vga_req = 1'b0;
    got = 0; n = 0;
    while (n < 4 && !got) begin @(negedge clk); n++; if (vga_rvalid) got = 1; end
    chk("vga_rvalid_after_disable", 64'(got), 64'(1));
    @(posedge clk); #1 enabledVGA = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Asynchronous reset during a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h5A;
    n = 0; got = 0;
    while (n < 10 && !got) begin @(negedge clk); n++; if (cpu_ack) got = 1; end
    chk("rst_test_ack", 64'(got), 64'(1));
    chk("rst_test_we_before", 64'(mem_we), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("ack_drops_async", 64'(cpu_ack), 64'(0));
    chk("we_drops_async", 64'(mem_we), 64'(0));
    cpu_req = 1'b0; cpu_we = 1'b0;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    chk("outputs_after_reset", out_vec(), 64'(0));
    seen = 0;
    repeat (4) begin @(negedge clk); if (cpu_rvalid) seen = 1; end
    chk("no_rvalid_after_abort", 64'(seen), 64'(0));
    @(posedge clk); #1;
    cpu_access(1'b0, 16'h0300, 8'h00, lat);
    cpu_req = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Continuous requests from both sides: V,V,V,V,C repeating.
    grant_log.delete();
    max_lat = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) vga_read(16'h1000 + 16'(i), vlat);
        vga_req = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          cpu_access(1'b0, 16'h2000 + 16'(i), 8'h00, clat);
          if (clat > max_lat) max_lat = clat;
        end
        cpu_req = 1'b0;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("grant_count", 64'(grant_log.size()), 64'(50));
    for (int k = 0; k < 50 && k < grant_log.size(); k++)
      chk($sformatf("grant_%0d", k), 64'(grant_log[k]), 64'((k % 5 == 4) ? 8'h43 : 8'h56));
    chk("cpu_wait_le_10", 64'(max_lat <= 10), 64'(1));
    chk("cpu_q_drained", 64'(cpu_exp_q.size()), 64'(0));
    chk("vga_q_drained", 64'(vga_exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
